mem_phase_sequencer: RTL and testbench
======================================

# mem_phase_sequencer

Upstream sequencer for the unified single-port instruction/data memory. Time-multiplexes the memory between instruction fetch and load/store on alternating cycles by generating `sclk`. Accepts one data request at a time from the EX/MEM stage over a valid/ready handshake and registers the fetched instruction word and the load/store response. Performs alignment checking and correct load sign/zero extension before the result enters MEM/WB.

## Interface
- `ADDR_W`, 8, memory byte-address width
- `DATA_W`, 32, data/instruction width
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `pc`  in  ADDR_W  fetch byte address from IF
- `fetch_en`  in  1  IF not stalled; capture instruction this FETCH phase
- `req_valid`  in  1  data request present
- `req_ready`  out  1  request accepted when `req_valid && req_ready`
- `req_write`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 word, 01 half, 10 byte, 11 illegal
- `req_signed`  in  1  sign-extend load result
- `req_addr`  in  ADDR_W  data-region offset; memory adds its data base
- `req_wdata`  in  DATA_W  store data
- `sclk`  out  1  1 = FETCH phase, 0 = DATA phase
- `mem_addr`  out  ADDR_W  memory address
- `MemRead`, `MemWrite`  out  1  memory strobes
- `signed_inst`  out  1  always 0 (extension done here)
- `AU_inst_sel`  out  2  size code to memory
- `mem_wdata`  out  DATA_W  store data to memory
- `mem_rdata`  in  DATA_W  memory read data (combinational)
- `instr`  out  DATA_W  registered instruction word
- `instr_valid`  out  1  one-cycle pulse, `instr` updated
- `resp_valid`  out  1  one-cycle pulse, request completed
- `resp_rdata`  out  DATA_W  extended load data; 0 for stores/faults
- `misalign`  out  1  qualifies `resp_valid`: request faulted, not issued

## Operation
- Phase FSM: FETCH ↔ DATA, toggles every `clk`. `sclk` = (phase == FETCH), registered.
- FETCH cycle: `mem_addr = pc`, strobes 0. At the closing edge, if `fetch_en`, `instr <= mem_rdata` and `instr_valid <= 1`; otherwise `instr` holds and `instr_valid <= 0`.
- Holding register: one entry (`pending`, addr, size, signed, write, wdata). `req_ready = !pending`. A handshake sets `pending`.
- DATA cycle with `pending`:
  - If aligned: `mem_addr = addr`, `AU_inst_sel = size`, `MemRead = !write`, `MemWrite = write`, `mem_wdata = wdata`.
  - Misaligned (word with `addr[1:0]≠0`, half with `addr[0]≠0`, or size 11): both strobes held 0.
  - Closing edge: `pending <= 0`, `resp_valid <= 1`, `misalign <=` fault flag, `resp_rdata <=` extended data (loads), else 0.
- DATA cycle without `pending`: strobes 0, `mem_addr = 0`, `AU_inst_sel = 00`.
- Extension: word passes through. Half: bit 15 replicated if signed, else zeros. Byte: bit 7 replicated if signed, else zeros.
- Address arithmetic is 8-bit and wraps modulo 256. No range check.

## Timing
- Reset values:
  - phase FETCH, `sclk` = 1, `pending` = 0, `req_ready` = 1.
  - All strobes 0, `signed_inst` = 0, `AU_inst_sel` = 00.
  - `mem_addr`, `mem_wdata`, `instr`, `resp_rdata` = 0.
  - `instr_valid`, `resp_valid`, `misalign` = 0.
- Request latency: accepted at the end of cycle N.
  - If cycle N+1 is DATA, `resp_valid` is high in N+2.
  - Otherwise `resp_valid` is high in N+3.
- `req_ready` is low from the cycle after acceptance through the issue cycle, and high again in the `resp_valid` cycle.
- Peak throughput: one request per 2 cycles. `MemWrite` is never high while `sclk` = 1.
- A request presented during its own issue cycle is not accepted, because `req_ready` is 0.
- Reset asserted mid-request: the pending request is dropped, no write occurs after reset assertion, and no `resp_valid` follows.

## Structure
- Package `mem_pkg` holds:
  - size codes `SZ_WORD`/`SZ_HALF`/`SZ_BYTE`/`SZ_ILL`
  - phase enum `PH_FETCH`/`PH_DATA`
  - `DATA_BASE` = 128, for benches
- Sub-module `load_ext`: combinational size/signed extender, reused by the bench model.

## Test plan
- Fetch: reset, `fetch_en` = 1, `pc` = 12 → `instr` = 0x029402B3 and `instr_valid` pulse after the first FETCH cycle. Strobes are 0 throughout FETCH.
- Load word: `req_addr` = 0, size 00 → `resp_rdata` = 5, `misalign` = 0, latency 2 or 3 cycles per phase.
- Store then load: SW 0x80 to offset 16, then LB signed and LBU at offset 16.
  - LB signed → 0xFFFFFF80; LBU → 0x00000080.
  - `MemWrite` is high for exactly one `sclk` = 0 cycle.
- Misalign: LW at offset 2 and LH at offset 1 → `resp_valid` with `misalign` = 1 and `resp_rdata` = 0. No strobe asserted; memory contents unchanged.
- Back-to-back: `req_valid` held high with two loads (offsets 4, 8) → responses 3 then 7. `req_ready` low between them; no request lost or duplicated.
- Reset mid-request: assert `rst` after acceptance, before issue → no `MemWrite`, no `resp_valid`. All outputs at reset values immediately (asynchronous).

Source files
------------

// File: rtl/mem_phase_sequencer_pkg.sv
// Shared definitions for the unified-memory phase sequencer: size codes,
// phase encoding, data-region base and the alignment rule.
package mem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Memory alternates between serving instruction fetch and load/store.
  typedef enum logic {
    PH_FETCH = 1'b0,
    PH_DATA  = 1'b1
  } phase_e;

  // Offset the memory adds to data-phase addresses; the sequencer never
  // applies it, it is published so models of the memory agree on it.
  localparam int DATA_BASE = 128;

  // A request faults when its size is illegal or its address is not a
  // multiple of the access size.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lsb);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_WORD: bad = (addr_lsb != 2'b00);
      SZ_HALF: bad = addr_lsb[0];
      SZ_BYTE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_phase_sequencer_load_ext.sv
// Combinational load extender: narrows raw memory data to the access size
// and fills the upper bits with zeros or the replicated sign bit.
import mem_pkg::*;

module load_ext #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  output logic [DATA_W-1:0] data_o
);

  // Select the extension for the access size; illegal size yields zero.
  always_comb begin
    data_o = '0;
    case (size_i)
      SZ_WORD: data_o = data_i;
      SZ_HALF: data_o = {{(DATA_W-16){signed_i & data_i[15]}}, data_i[15:0]};
      SZ_BYTE: data_o = {{(DATA_W-8){signed_i & data_i[7]}}, data_i[7:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_phase_sequencer.sv
// Phase sequencer for the single-port instruction/data memory. Even cycles
// fetch an instruction at pc, odd cycles serve at most one buffered
// load/store. The fetched word and the load/store response are registered.
//
// Handshake: a request transfers on any rising edge where req_valid and
// req_ready are both high; req_ready is high exactly when the one-entry
// holding register is empty. The requester must hold its fields stable
// while req_valid is high and req_ready is low. There is no response
// back-pressure: resp_valid is a single-cycle pulse.
import mem_pkg::*;

module mem_phase_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_en,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              sclk,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              signed_inst,
  output logic [1:0]        AU_inst_sel,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              misalign
);

  phase_e            phase_q, phase_d;
  logic              sclk_q;

  logic              pend_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] instr_q;
  logic              instr_valid_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              misalign_q;

  logic              accept;
  logic              issue;
  logic              fault;
  logic [DATA_W-1:0] ext_data;

  assign accept = req_valid && !pend_q;
  assign fault  = is_misaligned(size_q, addr_q[1:0]);

  load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .data_i   (mem_rdata),
    .size_i   (size_q),
    .signed_i (signed_q),
    .data_o   (ext_data)
  );

  // Phase register; sclk is a flop that mirrors the phase so it is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_FETCH;
      sclk_q  <= 1'b1;
    end else begin
      phase_q <= phase_d;
      sclk_q  <= (phase_d == PH_FETCH);
    end
  end

  // Next phase and memory-side decode. Reset forces every memory output
  // low so nothing is strobed while reset is applied.
  always_comb begin
    phase_d     = (phase_q == PH_FETCH) ? PH_DATA : PH_FETCH;
    issue       = (phase_q == PH_DATA) && pend_q;
    mem_addr    = '0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    AU_inst_sel = SZ_WORD;
    mem_wdata   = '0;
    if (!rst) begin
      if (phase_q == PH_FETCH) begin
        mem_addr = pc;
      end else if (pend_q && !fault) begin
        mem_addr    = addr_q;
        AU_inst_sel = size_q;
        MemRead     = !write_q;
        MemWrite    = write_q;
        mem_wdata   = wdata_q;
      end
    end
  end

  // One-entry holding register: filled on handshake, drained in its issue cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q   <= 1'b0;
      addr_q   <= '0;
      size_q   <= SZ_WORD;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
    end else if (issue) begin
      pend_q <= 1'b0;
    end else if (accept) begin
      pend_q   <= 1'b1;
      addr_q   <= req_addr;
      size_q   <= req_size;
      signed_q <= req_signed;
      write_q  <= req_write;
      wdata_q  <= req_wdata;
    end
  end

  // Instruction capture at the end of each fetch phase when IF is not stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
    end else if ((phase_q == PH_FETCH) && fetch_en) begin
      instr_q       <= mem_rdata;
      instr_valid_q <= 1'b1;
    end else begin
      instr_valid_q <= 1'b0;
    end
  end

  // Response register: one pulse per issued request, data only for good loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      misalign_q   <= 1'b0;
    end else begin
      resp_valid_q <= issue;
      misalign_q   <= issue && fault;
      if (issue && !write_q && !fault) begin
        resp_rdata_q <= ext_data;
      end else begin
        resp_rdata_q <= '0;
      end
    end
  end

  assign req_ready   = !pend_q;
  assign sclk        = sclk_q;
  assign signed_inst = 1'b0;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_mem_phase_sequencer.sv
// Directed bench for mem_phase_sequencer with a byte-addressed memory model
// that adds the data base during the data phase.
module tb_mem_phase_sequencer;
  import mem_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] pc;
  logic              fetch_en;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              sclk;
  logic [ADDR_W-1:0] mem_addr;
  logic              MemRead;
  logic              MemWrite;
  logic              signed_inst;
  logic [1:0]        AU_inst_sel;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              misalign;

  int errors = 0;
  int checks = 0;

  int wr_cycles = 0;
  int rd_cycles = 0;
  int resp_cnt = 0;
  int strobe_in_fetch = 0;

  logic [7:0] mem [0:255];
  logic [7:0] ea;

  mem_phase_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_en(fetch_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .sclk(sclk), .mem_addr(mem_addr),
    .MemRead(MemRead), .MemWrite(MemWrite), .signed_inst(signed_inst),
    .AU_inst_sel(AU_inst_sel), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .misalign(misalign)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational little-endian read, sized write on the edge.
  always_comb begin
    ea = sclk ? mem_addr : 8'(mem_addr + 8'(DATA_BASE));
    mem_rdata = {mem[8'(ea + 8'd3)], mem[8'(ea + 8'd2)], mem[8'(ea + 8'd1)], mem[ea]};
  end

  always @(posedge clk) begin
    if (MemWrite) begin
      mem[ea] <= mem_wdata[7:0];
      if (AU_inst_sel != SZ_BYTE) mem[8'(ea + 8'd1)] <= mem_wdata[15:8];
      if (AU_inst_sel == SZ_WORD) begin
        mem[8'(ea + 8'd2)] <= mem_wdata[23:16];
        mem[8'(ea + 8'd3)] <= mem_wdata[31:24];
      end
    end
  end

  // Strobe / response monitor
  always @(negedge clk) begin
    if (MemWrite) wr_cycles++;
    if (MemRead) rd_cycles++;
    if (resp_valid) resp_cnt++;
    if (sclk && (MemRead || MemWrite)) strobe_in_fetch++;
  end

  function automatic logic [31:0] data_word(input int off);
    int a;
    a = DATA_BASE + off;
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  task automatic init_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    {mem[15], mem[14], mem[13], mem[12]} = 32'h0294_02B3;
    {mem[DATA_BASE+3], mem[DATA_BASE+2], mem[DATA_BASE+1], mem[DATA_BASE+0]} = 32'd5;
    {mem[DATA_BASE+7], mem[DATA_BASE+6], mem[DATA_BASE+5], mem[DATA_BASE+4]} = 32'd3;
    {mem[DATA_BASE+11], mem[DATA_BASE+10], mem[DATA_BASE+9], mem[DATA_BASE+8]} = 32'd7;
    {mem[DATA_BASE+19], mem[DATA_BASE+18], mem[DATA_BASE+17], mem[DATA_BASE+16]} = 32'hAAAA_AAAA;
  endtask

  // Driver: present one request, wait for its response; returns observations.
  task automatic drive_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [7:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic mis,
                           output int lat, output int exp_lat,
                           output logic ready_bad, output logic timeout);
    int k;
    @(negedge clk);
    req_write = w; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    exp_lat = sclk ? 3 : 2;
    ready_bad = 1'b0;
    while (!resp_valid && lat < 8) begin
      if (req_ready) ready_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    timeout = !resp_valid;
    if (resp_valid && !req_ready) ready_bad = 1'b1;
    rd = resp_rdata;
    mis = misalign;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc = 8'd12; fetch_en = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL rst_sclk: got %b exp 1", sclk); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", req_ready); end
    checks++; if ({MemRead, MemWrite, signed_inst} !== 3'b000) begin errors++; $display("FAIL rst_strobes: got %b exp 000", {MemRead, MemWrite, signed_inst}); end
    checks++; if (AU_inst_sel !== 2'b00) begin errors++; $display("FAIL rst_au_sel: got %b exp 00", AU_inst_sel); end
    checks++; if (mem_addr !== 8'd0) begin errors++; $display("FAIL rst_mem_addr: got %0h exp 0", mem_addr); end
    checks++; if (mem_wdata !== 32'd0) begin errors++; $display("FAIL rst_mem_wdata: got %0h exp 0", mem_wdata); end
    checks++; if (instr !== 32'd0) begin errors++; $display("FAIL rst_instr: got %0h exp 0", instr); end
    checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL rst_resp_rdata: got %0h exp 0", resp_rdata); end
    checks++; if ({instr_valid, resp_valid, misalign} !== 3'b000) begin errors++; $display("FAIL rst_pulses: got %b exp 000", {instr_valid, resp_valid, misalign}); end
  endtask

  task automatic test_fetch();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (mem_addr !== 8'd12) begin errors++; $display("FAIL fetch_addr: got %0h exp c", mem_addr); end
    checks++; if ({MemRead, MemWrite} !== 2'b00) begin errors++; $display("FAIL fetch_strobes: got %b exp 00", {MemRead, MemWrite}); end
    @(negedge clk);
    checks++; if (instr !== 32'h0294_02B3) begin errors++; $display("FAIL fetch_instr: got %h exp 029402b3", instr); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid: got %b exp 1", instr_valid); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL fetch_phase: got %b exp 0", sclk); end
    fetch_en = 1'b0;
    pc = 8'd0;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fetch_pulse_end: got %b exp 0", instr_valid); end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fetch_stall_valid: got %b exp 0", instr_valid); end
    checks++; if (instr !== 32'h0294_02B3) begin errors++; $display("FAIL fetch_stall_hold: got %h exp 029402b3", instr); end
  endtask

  task automatic test_load_word();
    logic [31:0] rd; logic mis, rb, to; int lat, el;
    for (int n = 0; n < 2; n++) begin
      if (n == 1) @(negedge clk);
      drive_req(1'b0, SZ_WORD, 1'b0, 8'd0, 32'd0, rd, mis, lat, el, rb, to);
      checks++; if (to) begin errors++; $display("FAIL lw_timeout: got none exp resp_valid"); end
      checks++; if (rd !== 32'd5) begin errors++; $display("FAIL lw_data: got %0h exp 5", rd); end
      checks++; if (mis !== 1'b0) begin errors++; $display("FAIL lw_misalign: got %b exp 0", mis); end
      checks++; if (lat != el) begin errors++; $display("FAIL lw_latency: got %0d exp %0d", lat, el); end
      checks++; if (rb) begin errors++; $display("FAIL lw_ready: got bad ready sequence exp low then high"); end
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic mis, rb, to; int lat, el; int wr0;
    wr0 = wr_cycles;
    drive_req(1'b1, SZ_WORD, 1'b0, 8'd16, 32'h80, rd, mis, lat, el, rb, to);
    checks++; if (to || rd !== 32'd0 || mis !== 1'b0) begin errors++; $display("FAIL sw_resp: got to=%b rd=%0h mis=%b exp 0 0 0", to, rd, mis); end
    checks++; if (lat != el) begin errors++; $display("FAIL sw_latency: got %0d exp %0d", lat, el); end
    checks++; if (wr_cycles - wr0 != 1) begin errors++; $display("FAIL sw_write_cycles: got %0d exp 1", wr_cycles - wr0); end
    checks++; if (data_word(16) !== 32'h0000_0080) begin errors++; $display("FAIL sw_mem: got %h exp 00000080", data_word(16)); end
    drive_req(1'b0, SZ_BYTE, 1'b1, 8'd16, 32'd0, rd, mis, lat, el, rb, to);
    checks++; if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_signed: got %h exp ffffff80", rd); end
    drive_req(1'b0, SZ_BYTE, 1'b0, 8'd16, 32'd0, rd, mis, lat, el, rb, to);
    checks++; if (rd !== 32'h0000_0080) begin errors++; $display("FAIL lbu: got %h exp 00000080", rd); end
    drive_req(1'b1, SZ_BYTE, 1'b0, 8'd17, 32'h0000_00F0, rd, mis, lat, el, rb, to);
    checks++; if (data_word(16) !== 32'h0000_F080) begin errors++; $display("FAIL sb_mem: got %h exp 0000f080", data_word(16)); end
    drive_req(1'b0, SZ_HALF, 1'b1, 8'd16, 32'd0, rd, mis, lat, el, rb, to);
    checks++; if (rd !== 32'hFFFF_F080) begin errors++; $display("FAIL lh_signed: got %h exp fffff080", rd); end
    drive_req(1'b0, SZ_HALF, 1'b0, 8'd16, 32'd0, rd, mis, lat, el, rb, to);
    checks++; if (rd !== 32'h0000_F080) begin errors++; $display("FAIL lhu: got %h exp 0000f080", rd); end
    checks++; if (strobe_in_fetch != 0) begin errors++; $display("FAIL strobe_in_fetch: got %0d exp 0", strobe_in_fetch); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic mis, rb, to; int lat, el; int wr0, rd0;
    wr0 = wr_cycles; rd0 = rd_cycles;
    drive_req(1'b0, SZ_WORD, 1'b0, 8'd2, 32'd0, rd, mis, lat, el, rb, to);
    checks++; if (to || mis !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL mis_lw: got to=%b mis=%b rd=%0h exp 0 1 0", to, mis, rd); end
    drive_req(1'b0, SZ_HALF, 1'b1, 8'd1, 32'd0, rd, mis, lat, el, rb, to);
    checks++; if (to || mis !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL mis_lh: got to=%b mis=%b rd=%0h exp 0 1 0", to, mis, rd); end
    drive_req(1'b1, SZ_WORD, 1'b0, 8'd2, 32'hDEAD_BEEF, rd, mis, lat, el, rb, to);
    checks++; if (to || mis !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL mis_sw: got to=%b mis=%b rd=%0h exp 0 1 0", to, mis, rd); end
    drive_req(1'b0, SZ_ILL, 1'b0, 8'd0, 32'd0, rd, mis, lat, el, rb, to);
    checks++; if (to || mis !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL mis_size: got to=%b mis=%b rd=%0h exp 0 1 0", to, mis, rd); end
    checks++; if (wr_cycles != wr0 || rd_cycles != rd0) begin errors++; $display("FAIL mis_strobes: got wr=%0d rd=%0d exp 0 0", wr_cycles - wr0, rd_cycles - rd0); end
    checks++; if (data_word(0) !== 32'd5) begin errors++; $display("FAIL mis_mem: got %h exp 00000005", data_word(0)); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] e;
    int n_acc, n_resp, rd0;
    logic will_acc;
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd7);
    n_acc = 0; n_resp = 0; rd0 = rd_cycles;
    @(negedge clk);
    req_write = 1'b0; req_size = SZ_WORD; req_signed = 1'b0; req_addr = 8'd4;
    req_valid = 1'b1;
    will_acc = req_valid && req_ready;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        n_resp++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_resp: got %h exp none", resp_rdata);
        end else begin
          e = exp_q.pop_front();
          if (resp_rdata !== e) begin errors++; $display("FAIL b2b_data: got %h exp %h", resp_rdata, e); end
        end
      end
      if (will_acc) begin
        n_acc++;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low: got %b exp 0", req_ready); end
        if (n_acc == 1) req_addr = 8'd8;
        else req_valid = 1'b0;
      end
      will_acc = req_valid && req_ready;
    end
    checks++; if (n_acc != 2 || n_resp != 2) begin errors++; $display("FAIL b2b_counts: got acc=%0d resp=%0d exp 2 2", n_acc, n_resp); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing: got %0d left exp 0", exp_q.size()); end
    checks++; if (rd_cycles - rd0 != 2) begin errors++; $display("FAIL b2b_reads: got %0d exp 2", rd_cycles - rd0); end
  endtask

  task automatic test_reset_mid();
    int k, wr0, resp0;
    @(negedge clk);
    k = 0;
    while (sclk !== 1'b0 && k < 4) begin
      @(negedge clk);
      k++;
    end
    req_write = 1'b1; req_size = SZ_WORD; req_signed = 1'b0; req_addr = 8'd20;
    req_wdata = 32'h1234_5678; req_valid = 1'b1;
    wr0 = wr_cycles; resp0 = resp_cnt;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_accepted: got ready %b exp 0", req_ready); end
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1 || sclk !== 1'b1) begin errors++; $display("FAIL mid_ready_sclk: got %b%b exp 11", req_ready, sclk); end
    checks++; if ({MemRead, MemWrite} !== 2'b00 || mem_addr !== 8'd0 || mem_wdata !== 32'd0) begin errors++; $display("FAIL mid_mem_side: got rd=%b wr=%b a=%0h wd=%0h exp all 0", MemRead, MemWrite, mem_addr, mem_wdata); end
    checks++; if (instr !== 32'd0 || resp_rdata !== 32'd0) begin errors++; $display("FAIL mid_regs: got instr=%h rdata=%h exp 0 0", instr, resp_rdata); end
    checks++; if ({instr_valid, resp_valid, misalign} !== 3'b000) begin errors++; $display("FAIL mid_pulses: got %b exp 000", {instr_valid, resp_valid, misalign}); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (wr_cycles != wr0) begin errors++; $display("FAIL mid_no_write: got %0d writes exp 0", wr_cycles - wr0); end
    checks++; if (resp_cnt != resp0) begin errors++; $display("FAIL mid_no_resp: got %0d exp 0", resp_cnt - resp0); end
    checks++; if (data_word(20) !== 32'd0) begin errors++; $display("FAIL mid_mem: got %h exp 00000000", data_word(20)); end
  endtask

  initial begin
    init_mem();
    test_reset();
    test_fetch();
    test_load_word();
    test_store_load();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
